// File: rtl/pipeline_5_ma_lsu.sv
// Memory-access stage: completes the AHB3-Lite data phase issued in EX, aligns load data, writes MA/WB.
// Optional bus-error reporting (ERR state, LBUSERR/SBUSERR codes) is built when MA_BUSERR_EN is defined.
package p_hardisc;
  localparam int ICTRL_W   = 7;
  localparam int IMISCON_W = 3;
  typedef logic [ICTRL_W-1:0]   ictrl;
  typedef logic [IMISCON_W-1:0] imiscon;
  typedef logic [3:0]           f_part;
  typedef logic [4:0]           rf_add;
  localparam int ICTRL_UNIT_BRU = 0;
  localparam int ICTRL_UNIT_ALU = 1;
  localparam int ICTRL_UNIT_LSU = 2;
  localparam int ICTRL_UNIT_CSR = 3;
  localparam int ICTRL_UNIT_MDU = 4;
  localparam int ICTRL_REG_DEST = 5;
  localparam int ICTRL_RVC      = 6;
  localparam imiscon IMISCON_FREE    = 3'd0;
  localparam imiscon IMISCON_ILLE    = 3'd1;
  localparam imiscon IMISCON_DSCR    = 3'd2;
  localparam imiscon IMISCON_LBUSERR = 3'd3;
  localparam imiscon IMISCON_SBUSERR = 3'd4;
endpackage

module pipeline_5_ma_lsu
  import p_hardisc::*;
(
  input  logic                 s_clk_i,
  input  logic                 s_reset_i,
  input  logic                 s_flush_i,
  input  logic [ICTRL_W-1:0]   s_exma_ictrl_i,
  input  logic [IMISCON_W-1:0] s_exma_imiscon_i,
  input  logic [3:0]           s_exma_f_i,
  input  logic [4:0]           s_exma_rd_i,
  input  logic [31:0]          s_exma_val_i,
  input  logic                 s_exma_tstrd_i,
  input  logic [31:0]          s_hrdata_i,
  input  logic                 s_hready_i,
  input  logic                 s_hresp_i,
  output logic                 s_stall_o,
  output logic [ICTRL_W-1:0]   s_mawb_ictrl_o,
  output logic [IMISCON_W-1:0] s_mawb_imiscon_o,
  output logic [4:0]           s_mawb_rd_o,
  output logic [31:0]          s_mawb_val_o,
  output logic                 s_busy_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_ERR = 2'd2} state_e;

  state_e state_q, state_d;

  // Instruction whose data phase is in flight; EX/MA is not sampled while busy.
  logic [ICTRL_W-1:0] ictrl_q, ictrl_d;
  logic [3:0]         f_q, f_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        addr_q, addr_d;
  logic               flush_q, flush_d;

  logic [ICTRL_W-1:0]   mawb_ictrl_q, mawb_ictrl_d;
  logic [IMISCON_W-1:0] mawb_imiscon_q, mawb_imiscon_d;
  logic [4:0]           mawb_rd_q, mawb_rd_d;
  logic [31:0]          mawb_val_q, mawb_val_d;

  logic        lsu_go;
  logic        bus_err;
  logic        kill;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign lsu_go = s_exma_ictrl_i[ICTRL_UNIT_LSU] & s_exma_tstrd_i &
                  (s_exma_imiscon_i == IMISCON_FREE);
  assign kill   = flush_q | s_flush_i;

`ifdef MA_BUSERR_EN
  assign bus_err = s_hresp_i;
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    ld_byte = s_hrdata_i[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = s_hrdata_i[15:8];
      2'd2:    ld_byte = s_hrdata_i[23:16];
      2'd3:    ld_byte = s_hrdata_i[31:24];
      default: ld_byte = s_hrdata_i[7:0];
    endcase
    ld_half = addr_q[1] ? s_hrdata_i[31:16] : s_hrdata_i[15:0];
    case (f_q[1:0])
      2'b00:   ld_val = {{24{ld_byte[7] & ~f_q[2]}}, ld_byte};
      2'b01:   ld_val = {{16{ld_half[15] & ~f_q[2]}}, ld_half};
      default: ld_val = s_hrdata_i;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_q        <= S_IDLE;
      ictrl_q        <= '0;
      f_q            <= '0;
      rd_q           <= '0;
      addr_q         <= '0;
      flush_q        <= 1'b0;
      mawb_ictrl_q   <= '0;
      mawb_imiscon_q <= IMISCON_FREE;
      mawb_rd_q      <= '0;
      mawb_val_q     <= '0;
    end else begin
      state_q        <= state_d;
      ictrl_q        <= ictrl_d;
      f_q            <= f_d;
      rd_q           <= rd_d;
      addr_q         <= addr_d;
      flush_q        <= flush_d;
      mawb_ictrl_q   <= mawb_ictrl_d;
      mawb_imiscon_q <= mawb_imiscon_d;
      mawb_rd_q      <= mawb_rd_d;
      mawb_val_q     <= mawb_val_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (lsu_go) state_d = S_DATA;
      S_DATA: begin
`ifdef MA_BUSERR_EN
        if (s_hresp_i && !s_hready_i) state_d = S_ERR;
        else if (s_hready_i)          state_d = S_IDLE;
`else
        if (s_hready_i) state_d = S_IDLE;
`endif
      end
`ifdef MA_BUSERR_EN
      S_ERR:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs, capture and MA/WB next value
  always_comb begin
    s_stall_o      = 1'b0;
    ictrl_d        = ictrl_q;
    f_d            = f_q;
    rd_d           = rd_q;
    addr_d         = addr_q;
    flush_d        = flush_q;
    mawb_ictrl_d   = '0;
    mawb_imiscon_d = IMISCON_FREE;
    mawb_rd_d      = '0;
    mawb_val_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (lsu_go) begin
          // An accepted address phase must still complete even if flushed now.
          ictrl_d = s_exma_ictrl_i;
          f_d     = s_exma_f_i;
          rd_d    = s_exma_rd_i;
          addr_d  = s_exma_val_i;
          flush_d = s_flush_i;
        end else if (!s_flush_i) begin
          mawb_ictrl_d   = s_exma_ictrl_i;
          mawb_imiscon_d = s_exma_imiscon_i;
          mawb_rd_d      = s_exma_rd_i;
          mawb_val_d     = s_exma_val_i;
        end
      end
      S_DATA: begin
        s_stall_o = ~s_hready_i & ~flush_q;
        flush_d   = kill;
        if (s_hready_i && !kill) begin
          mawb_ictrl_d = ictrl_q;
          if (bus_err) begin
            mawb_imiscon_d = f_q[3] ? IMISCON_SBUSERR : IMISCON_LBUSERR;
            mawb_val_d     = addr_q;
          end else begin
            mawb_rd_d  = f_q[3] ? 5'd0 : rd_q;
            mawb_val_d = f_q[3] ? addr_q : ld_val;
          end
        end
      end
      S_ERR: begin
        s_stall_o = ~flush_q;
        flush_d   = kill;
        if (!kill) begin
          mawb_ictrl_d   = ictrl_q;
          mawb_imiscon_d = f_q[3] ? IMISCON_SBUSERR : IMISCON_LBUSERR;
          mawb_val_d     = addr_q;
        end
      end
      default: ;
    endcase
    if (state_d == S_IDLE && state_q != S_IDLE) flush_d = 1'b0;
  end

  assign s_busy_o         = (state_q != S_IDLE);
  assign s_mawb_ictrl_o   = mawb_ictrl_q;
  assign s_mawb_imiscon_o = mawb_imiscon_q;
  assign s_mawb_rd_o      = mawb_rd_q;
  assign s_mawb_val_o     = mawb_val_q;

endmodule
